// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
// Purpose : Groups the fetch stage's pipeline-control inputs, execute-stage
//           redirect inputs, instruction memory path and IF/ID outputs into
//           one bundle.
// Modports:
//   slave  - the fetch stage itself (consumes control/redirect/instruction,
//            produces PCF_o and the decode-stage register contents)
//   master - the surrounding pipeline (hazard unit, execute stage and
//            instruction memory) that drives the controls and reads results
// Signals :
//   StallF_i, StallD_i, FlushD_i      pipeline control
//   PCSrcE_i[1:0], PCTargetE_i,
//   ALUResultE_i                      execute-stage redirect request/targets
//   InstrF_i                          instruction memory data at PCF_o
//   PCF_o                             fetch address
//   InstrD_o, PCD_o, PCPlus4D_o,
//   ValidD_o                          IF/ID register contents
//   Rs1D_o, Rs2D_o, RdD_o             register fields of InstrD_o
//   RedirectF_o                       execute stage is redirecting fetch
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  StallF_i;
  logic                  StallD_i;
  logic                  FlushD_i;
  logic [1:0]            PCSrcE_i;
  logic [DATA_WIDTH-1:0] PCTargetE_i;
  logic [DATA_WIDTH-1:0] ALUResultE_i;
  logic [DATA_WIDTH-1:0] InstrF_i;
  logic [DATA_WIDTH-1:0] PCF_o;
  logic [DATA_WIDTH-1:0] InstrD_o;
  logic [DATA_WIDTH-1:0] PCD_o;
  logic [DATA_WIDTH-1:0] PCPlus4D_o;
  logic [4:0]            Rs1D_o;
  logic [4:0]            Rs2D_o;
  logic [4:0]            RdD_o;
  logic                  ValidD_o;
  logic                  RedirectF_o;

  // The fetch stage's own view
  modport slave (
    input  StallF_i, StallD_i, FlushD_i, PCSrcE_i, PCTargetE_i,
           ALUResultE_i, InstrF_i,
    output PCF_o, InstrD_o, PCD_o, PCPlus4D_o, Rs1D_o, Rs2D_o, RdD_o,
           ValidD_o, RedirectF_o
  );

  // The rest of the pipeline's view
  modport master (
    output StallF_i, StallD_i, FlushD_i, PCSrcE_i, PCTargetE_i,
           ALUResultE_i, InstrF_i,
    input  PCF_o, InstrD_o, PCD_o, PCPlus4D_o, Rs1D_o, Rs2D_o, RdD_o,
           ValidD_o, RedirectF_o
  );

endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Purpose : Instruction fetch stage of a 5-stage RISC-V pipeline. Holds the
//           PC register and the IF/ID pipeline register, selects the next PC
//           from sequential / branch-jal / jalr sources and inserts bubbles
//           on flush or redirect.
// Ports   :
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - fetch_stage_if.slave (controls, redirect targets, instruction
//           memory data in; fetch PC and decode-stage register out)
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP   = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] BIT0_MASK = ~DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_pcF;
  logic [DATA_WIDTH-1:0] r_instrD;
  logic [DATA_WIDTH-1:0] r_pcD;
  logic [DATA_WIDTH-1:0] r_pcPlus4D;
  logic                  r_validD;

  logic [DATA_WIDTH-1:0] w_pcPlus4F;
  logic [DATA_WIDTH-1:0] w_pcNext;
  logic                  w_redirect;
  logic                  w_flushD;

  // Redirect is only for the two defined sources; the reserved encoding
  // behaves as sequential fetch.
  assign w_redirect = (bus.PCSrcE_i == 2'b01) || (bus.PCSrcE_i == 2'b10);
  assign w_flushD   = bus.FlushD_i || w_redirect;
  assign w_pcPlus4F = r_pcF + PC_STEP;

  // Next-PC mux; jalr targets have bit 0 cleared as the ISA requires,
  // no other alignment is enforced here.
  always_comb begin
    w_pcNext = w_pcPlus4F;
    case (bus.PCSrcE_i)
      2'b01:   w_pcNext = bus.PCTargetE_i;
      2'b10:   w_pcNext = bus.ALUResultE_i & BIT0_MASK;
      default: w_pcNext = w_pcPlus4F;
    endcase
  end

  // PC register: a redirect must win over a stall, otherwise a taken
  // branch resolved during a load-use stall would be lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcF <= RESET_PC;
    end else if (w_redirect) begin
      r_pcF <= w_pcNext;
    end else if (!bus.StallF_i) begin
      r_pcF <= w_pcNext;
    end
  end

  // IF/ID register: flush (external or from redirect) beats stall, and a
  // bubble carries zeroed PCs and a cleared valid bit.
  always_ff @(posedge clk) begin
    if (rst || w_flushD) begin
      r_instrD   <= NOP_INSTR;
      r_pcD      <= '0;
      r_pcPlus4D <= '0;
      r_validD   <= 1'b0;
    end else if (!bus.StallD_i) begin
      r_instrD   <= bus.InstrF_i;
      r_pcD      <= r_pcF;
      r_pcPlus4D <= w_pcPlus4F;
      r_validD   <= 1'b1;
    end
  end

  assign bus.PCF_o       = r_pcF;
  assign bus.InstrD_o    = r_instrD;
  assign bus.PCD_o       = r_pcD;
  assign bus.PCPlus4D_o  = r_pcPlus4D;
  assign bus.ValidD_o    = r_validD;
  assign bus.RedirectF_o = w_redirect;
  assign bus.Rs1D_o      = r_instrD[19:15];
  assign bus.Rs2D_o      = r_instrD[24:20];
  assign bus.RdD_o       = r_instrD[11:7];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, instruction and address paths.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0) inserted on flush.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 StallF_i  input  1  hold PC register.
REQ-007 StallD_i  input  1  hold IF/ID register.
REQ-008 FlushD_i  input  1  replace IF/ID contents with bubble.
REQ-009 PCSrcE_i  input  2  PC select from execute stage: 00 sequential, 01 branch/jal target, 10 jalr target, 11 reserved.
REQ-010 PCTargetE_i  input  DATA_WIDTH  PCE+ExtImmE from execute stage.
REQ-011 ALUResultE_i  input  DATA_WIDTH  rs1+imm from execute stage (jalr).
REQ-012 InstrF_i  input  DATA_WIDTH  instruction memory read data, combinational on PCF_o.
REQ-013 PCF_o  output  DATA_WIDTH  current fetch address to instruction memory.
REQ-014 InstrD_o  output  DATA_WIDTH  decode-stage instruction.
REQ-015 PCD_o  output  DATA_WIDTH  decode-stage PC.
REQ-016 PCPlus4D_o  output  DATA_WIDTH  decode-stage PC+4.
REQ-017 Rs1D_o / Rs2D_o / RdD_o  output  5 each  InstrD_o[19:15] / [24:20] / [11:7].
REQ-018 ValidD_o  output  1  high when decode stage holds a real fetched instruction.
REQ-019 RedirectF_o  output  1  high in any cycle where PCSrcE_i is 01 or 10.

Function
REQ-020 PCPlus4F SHALL equal PCF_o + 4 modulo 2^DATA_WIDTH (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-021 Next PC SHALL be: 00 -> PCPlus4F; 01 -> PCTargetE_i; 10 -> ALUResultE_i with bit 0 cleared; 11 -> PCPlus4F (treated as sequential, RedirectF_o low).
REQ-022 PC register priority SHALL be: rst > redirect (PCSrcE_i 01/10) > StallF_i hold > load next PC; a redirect SHALL override StallF_i.
REQ-023 Internal flush SHALL equal FlushD_i OR RedirectF_o.
REQ-024 IF/ID register priority SHALL be: rst > internal flush > StallD_i hold > load {InstrF_i, PCF_o, PCPlus4F, ValidD=1}.
REQ-025 On flush: InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0, on the next edge.
REQ-026 Latency: instruction at PCF_o in cycle N SHALL appear on InstrD_o in cycle N+1 when unstalled and unflushed.
REQ-027 StallF_i=1 with StallD_i=0 and no flush SHALL load the (repeated) current instruction into decode; no PC advance.
REQ-028 Rs1D_o/Rs2D_o/RdD_o SHALL be purely combinational from InstrD_o, giving 0/0/0 for a bubble.
REQ-029 Redirect targets SHALL be loaded unmodified apart from REQ-021 bit-0 clearing; no alignment checking in this block.
REQ-030 Redirect and flush effects SHALL be visible on outputs only after the clock edge; PCF_o never changes combinationally.

Reset
REQ-031 While rst=1 at an edge: PCF_o=RESET_PC, InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0, regardless of all other inputs.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL take priority; first fetch after rst deasserts is from RESET_PC.
REQ-033 RedirectF_o is combinational and SHALL follow PCSrcE_i even during reset.

Verification
REQ-034 Reset then 3 free-running cycles, InstrF_i=PC-derived pattern -> PCF_o 0,4,8,12; InstrD_o lags one cycle, ValidD_o=1 from cycle 2.
REQ-035 PCF_o=0x10, PCSrcE_i=01, PCTargetE_i=0x40 -> next cycle PCF_o=0x40, InstrD_o=0x0000_0013, ValidD_o=0; following cycle InstrD_o=mem[0x40].
REQ-036 PCSrcE_i=10, ALUResultE_i=0x0000_0105 -> PCF_o=0x0000_0104 next cycle, decode bubbled.
REQ-037 StallF_i=StallD_i=1 for 2 cycles at PCF_o=0x20 -> PCF_o, InstrD_o, PCD_o unchanged; release -> PCF_o=0x24.
REQ-038 StallF_i=1 and PCSrcE_i=01 same cycle, target 0x80 -> PCF_o=0x80, decode bubble; and separately PCF_o=0xFFFF_FFFC sequential -> PCF_o=0x0000_0000.
REQ-039 rst=1 asserted while StallF_i=1 and PCSrcE_i=01 -> PCF_o=RESET_PC, InstrD_o=NOP_INSTR, ValidD_o=0 next cycle.
